// File: rtl/xsleena_pkg.sv
`default_nettype none
// ============================================================================
// Module      : xsleena_pkg
// Description : Shared types and constants for the graphics ROM-fetch arbiter.
//               Holds the arbiter state type, the channel count, the channel
//               indices and the round-robin successor helper.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package xsleena_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HIT   = 3'd1,
    ISSUE = 3'd2,
    WAIT  = 3'd3,
    DONE  = 3'd4
  } arb_state_t;

  localparam int         NCH    = 3;
  localparam logic [1:0] CH_OBJ = 2'd0;
  localparam logic [1:0] CH_BG1 = 2'd1;
  localparam logic [1:0] CH_BG2 = 2'd2;

  // Round-robin successor: OBJ -> BG1 -> BG2 -> OBJ
  function automatic logic [1:0] next_ch(input logic [1:0] ch);
    return (ch == CH_BG2) ? CH_OBJ : ch + 2'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/xsleena_rr_pick3.sv
`default_nettype none
// ============================================================================
// Module      : xsleena_rr_pick3
// Description : Combinational three-way round-robin picker. Searches the
//               pending vector starting at ptr and wrapping, and returns the
//               first pending channel as a one-hot grant.
// Ports       : pending[2:0] in  - channels with an unserved request
//               ptr[1:0]     in  - channel searched first (0..2)
//               grant[2:0]   out - one-hot granted channel
//               valid        out - some channel is granted
// Revision    : 1.0 - initial release
// ============================================================================
module xsleena_rr_pick3
  import xsleena_pkg::*;
(
  input  logic [2:0] pending,
  input  logic [1:0] ptr,
  output logic [2:0] grant,
  output logic       valid
);

  logic [1:0] w_c1;
  logic [1:0] w_c2;

  assign w_c1 = next_ch(ptr);
  assign w_c2 = next_ch(w_c1);

  always_comb begin
    grant = 3'b000;
    if (pending[ptr])
      grant[ptr] = 1'b1;
    else if (pending[w_c1])
      grant[w_c1] = 1'b1;
    else if (pending[w_c2])
      grant[w_c2] = 1'b1;
  end

  assign valid = |pending;

endmodule
`default_nettype wire

// File: rtl/xsleena_sdram_rom_arb.sv
`default_nettype none
// ============================================================================
// Module      : xsleena_sdram_rom_arb
// Description : Serialises the OBJ, BACK1 and BACK2 graphics ROM fetch
//               channels onto one SDRAM controller read port. Round-robin
//               fair, with a per-channel last-word cache so repeated fetches
//               of the same address skip the SDRAM. New grants are blocked
//               and caches invalidated while ROM download is active.
// Ports       : CLK, RST (sync, active high), DOWNLOAD
//               <ch>_addr/<ch>_req in, <ch>_rdy/<ch>_dout out, ch=obj,bg1,bg2
//               ctl_addr/ctl_rd out, ctl_ack/ctl_rdy/ctl_dout in
// Revision    : 1.0 - initial release
// ============================================================================
module xsleena_sdram_rom_arb
  import xsleena_pkg::*;
#(
  parameter int AW       = 25,
  parameter int DW       = 16,
  parameter bit CACHE_EN = 1'b1
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          DOWNLOAD,
  input  logic [AW-1:0] obj_addr,
  input  logic          obj_req,
  output logic          obj_rdy,
  output logic [DW-1:0] obj_dout,
  input  logic [AW-1:0] bg1_addr,
  input  logic          bg1_req,
  output logic          bg1_rdy,
  output logic [DW-1:0] bg1_dout,
  input  logic [AW-1:0] bg2_addr,
  input  logic          bg2_req,
  output logic          bg2_rdy,
  output logic [DW-1:0] bg2_dout,
  output logic [AW-1:0] ctl_addr,
  output logic          ctl_rd,
  input  logic          ctl_ack,
  input  logic          ctl_rdy,
  input  logic [DW-1:0] ctl_dout
);

  arb_state_t    r_state;
  logic [1:0]    r_ptr;
  logic [1:0]    r_gnt;
  logic [2:0]    r_served;
  logic [2:0]    r_valid;
  logic [2:0]    r_rdy;
  logic [AW-1:0] r_tag  [NCH];
  logic [DW-1:0] r_data [NCH];
  logic [DW-1:0] r_dout [NCH];

  logic [AW-1:0] w_addr [NCH];
  logic [2:0]    w_req;
  logic [2:0]    w_pend;
  logic [2:0]    w_gnt_oh;
  logic          w_gnt_vld;
  logic [1:0]    w_gnt_idx;
  logic          w_hit;
  logic [2:0]    w_rdy_nxt;
  logic [DW-1:0] w_rdy_dat;

  assign w_addr[CH_OBJ] = obj_addr;
  assign w_addr[CH_BG1] = bg1_addr;
  assign w_addr[CH_BG2] = bg2_addr;
  assign w_req          = {bg2_req, bg1_req, obj_req};
  assign w_pend         = w_req & ~r_served;

  xsleena_rr_pick3 u_pick (
    .pending (w_pend),
    .ptr     (r_ptr),
    .grant   (w_gnt_oh),
    .valid   (w_gnt_vld)
  );

  assign w_gnt_idx = w_gnt_oh[2] ? CH_BG2 : (w_gnt_oh[1] ? CH_BG1 : CH_OBJ);

  if (CACHE_EN) begin : g_cache
    assign w_hit = r_valid[w_gnt_idx] && (r_tag[w_gnt_idx] == w_addr[w_gnt_idx]);
  end else begin : g_nocache
    assign w_hit = 1'b0;
  end

  // Channel (one-hot) whose rdy pulse starts next cycle, and the data it gets.
  // Hits deliver the cached word; misses deliver ctl_dout as it arrives.
  always_comb begin
    w_rdy_nxt = 3'b000;
    w_rdy_dat = ctl_dout;
    case (r_state)
      IDLE: begin
        if (!DOWNLOAD && w_gnt_vld && w_hit) begin
          w_rdy_nxt = w_gnt_oh;
          w_rdy_dat = r_data[w_gnt_idx];
        end
      end
      ISSUE:   if (ctl_ack && ctl_rdy) w_rdy_nxt = 3'b001 << r_gnt;
      WAIT:    if (ctl_rdy)            w_rdy_nxt = 3'b001 << r_gnt;
      default: w_rdy_nxt = 3'b000;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state  <= IDLE;
      r_ptr    <= CH_OBJ;
      r_gnt    <= CH_OBJ;
      r_served <= 3'b000;
      r_valid  <= 3'b000;
      r_rdy    <= 3'b000;
      ctl_rd   <= 1'b0;
      ctl_addr <= '0;
      for (int i = 0; i < NCH; i++) begin
        r_tag[i]  <= '0;
        r_data[i] <= '0;
        r_dout[i] <= '0;
      end
    end else begin
      r_rdy <= w_rdy_nxt;
      // Served is set by a rdy only while req is still high, and any cycle
      // with req low clears it, so a fresh request needs a low gap.
      r_served <= (r_served | w_rdy_nxt) & w_req;
      for (int i = 0; i < NCH; i++) begin
        if (w_rdy_nxt[i]) r_dout[i] <= w_rdy_dat;
      end
      if (DOWNLOAD) r_valid <= 3'b000;

      case (r_state)
        IDLE: begin
          if (!DOWNLOAD && w_gnt_vld) begin
            r_gnt    <= w_gnt_idx;
            r_ptr    <= next_ch(w_gnt_idx);
            ctl_addr <= w_addr[w_gnt_idx];
            if (w_hit) begin
              r_state <= HIT;
            end else begin
              r_state <= ISSUE;
              ctl_rd  <= 1'b1;
            end
          end
        end
        HIT: r_state <= IDLE;
        ISSUE: begin
          if (ctl_ack) begin
            ctl_rd  <= 1'b0;
            r_state <= ctl_rdy ? DONE : WAIT;
          end
        end
        WAIT: if (ctl_rdy) r_state <= DONE;
        DONE: begin
          // r_dout of the granted channel already holds the fetched word.
          r_tag[r_gnt]  <= ctl_addr;
          r_data[r_gnt] <= r_dout[r_gnt];
          if (!DOWNLOAD) r_valid[r_gnt] <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign obj_rdy  = r_rdy[CH_OBJ];
  assign bg1_rdy  = r_rdy[CH_BG1];
  assign bg2_rdy  = r_rdy[CH_BG2];
  assign obj_dout = r_dout[CH_OBJ];
  assign bg1_dout = r_dout[CH_BG1];
  assign bg2_dout = r_dout[CH_BG2];

endmodule
`default_nettype wire
